light_sensor_emulator: RTL and testbench
========================================

// Module: light_sensor_emulator
// PURPOSE
//  SPI responder that emulates the ambient-light ADC seen by the light-sensor reader.
//  Serves a programmable 8-bit light value on SDATA whenever the master drives CS low and toggles SCLK.
//  Used for board-level loopback on the JA header and as the bench model for the reader.
//  cs_n and sclk are asynchronous to clk_10Mhz. They are synchronised internally.
// PARAMETERS
//  LEAD_ZEROS  4   zero bits shifted out before the data MSB
//  DATA_W      8   data bits per frame, sent MSB first
//  FRAME_BITS  16  total bits per frame; trailing zeros = FRAME_BITS-LEAD_ZEROS-DATA_W
// PORTS
//  clk_10Mhz     in   1       10 MHz system clock
//  reset         in   1       synchronous, active-high reset
//  sample_in     in   DATA_W  light value to serve
//  sample_valid  in   1       1-cycle strobe: load sample_in into holding register
//  cs_n          in   1       chip select from master, active low
//  sclk          in   1       serial clock from master (idles low)
//  sdata         out  1       serial data to master
//  sdata_oe      out  1       1 = sdata driven (top level tri-states when 0)
//  busy          out  1       1 while a frame is in progress (state != IDLE)
//  frame_done    out  1       1-cycle pulse: CS rose after a complete frame
//  frame_abort   out  1       1-cycle pulse: CS rose before FRAME_BITS falling edges
//  frame_count   out  16      completed-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset state:
//   - All outputs are 0. State is IDLE. Holding register is 0. Bit index is 0.
//   - Synchroniser flops reset to the idle values cs_n=1, sclk=0.
//  Synchronisation:
//   - cs_n and sclk each pass through 2 flops, then a third flop for edge detection.
//   - An edge becomes a 1-cycle internal strobe 3 clk cycles after the pin edge.
//   - The master must hold each SCLK phase for >=4 clk cycles; this is met at 1 MHz SCLK.
//  Holding register:
//   - Loads sample_in on sample_valid, in any state.
//   - Its value is copied into the shift register only at the CS falling edge.
//   - A sample_valid during a frame never alters the frame in flight.
//  State machine (IDLE, SHIFT, HOLD):
//   IDLE:
//    - sdata_oe=0, sdata=0.
//    - On CS fall: load the shift register, set bit index=0, set sdata_oe=1, go to SHIFT.
//   SHIFT:
//    - sdata = value of bit[index].
//    - Bits 0..LEAD_ZEROS-1 are 0.
//    - The next DATA_W bits are D[DATA_W-1]..D0.
//    - The remaining bits are 0.
//    - Each SCLK falling strobe increments the index.
//    - When the index reaches FRAME_BITS, go to HOLD.
//    - SCLK rising strobes change nothing; the master samples on the rising edge.
//   HOLD:
//    - sdata=0, sdata_oe=1.
//    - Extra SCLK edges are ignored.
//  CS rise in SHIFT or HOLD:
//   - Go to IDLE and set sdata_oe=0 on the same cycle as the strobe.
//   - From HOLD: pulse frame_done and increment frame_count.
//   - From SHIFT: pulse frame_abort; frame_count is unchanged.
//  Simultaneous strobes:
//   - CS rise takes priority over an SCLK strobe in the same cycle.
//   - A CS fall seen while not in IDLE cannot occur (CS must rise first).
//  reset asserted mid-frame:
//   - Returns to the reset state immediately.
//   - No frame_done or frame_abort pulse is produced.
//   - If CS is still low, the emulator waits in IDLE for the next CS fall.
//  Index width: $clog2(FRAME_BITS+1). The index saturates at FRAME_BITS and never wraps.
// TESTING
//  1. Load sample 0xA5, run a 16-clock frame at 1 MHz.
//     -> Master captures 0xA5 on bits 4..11, all other bits 0, frame_done=1 once, frame_count=1.
//  2. sample_valid with 0x3C mid-frame while serving 0xA5.
//     -> Current frame returns 0xA5; next frame returns 0x3C.
//  3. Raise CS after 7 SCLK falls.
//     -> frame_abort pulses, frame_count unchanged, sdata_oe=0; the next full frame is correct.
//  4. 20 SCLK cycles in one frame.
//     -> sdata=0 after bit 15, single frame_done, no index wrap.
//  5. Assert reset at bit 6 with CS low.
//     -> All outputs 0 the next cycle; no pulses; the next CS fall gives a correct frame.
//  6. Preload frame_count to 0xFFFF, complete a frame.
//     -> frame_count=0x0000.

Source files
------------

// File: rtl/light_sensor_emulator.sv
// light_sensor_emulator
//   SPI responder that emulates the ambient-light ADC seen by the light-sensor
//   reader. A programmable DATA_W-bit light value is served on sdata whenever the
//   master pulls cs_n low and toggles sclk. Each frame is LEAD_ZEROS zero bits,
//   then the data MSB first, then zero bits up to FRAME_BITS. Data changes after
//   sclk falling edges and the master samples it on rising edges.
//
// Ports
//   clk_10Mhz    in   10 MHz system clock
//   reset        in   synchronous, active-high reset
//   sample_in    in   light value to serve (DATA_W bits)
//   sample_valid in   1-cycle strobe: load sample_in into the holding register
//   cs_n         in   chip select from master, active low (asynchronous)
//   sclk         in   serial clock from master, idles low (asynchronous)
//   sdata        out  serial data to master
//   sdata_oe     out  1 = sdata driven (top level tri-states when 0)
//   busy         out  1 while a frame is in progress
//   frame_done   out  1-cycle pulse: cs_n rose after a complete frame
//   frame_abort  out  1-cycle pulse: cs_n rose before FRAME_BITS sclk falls
//   frame_count  out  completed-frame counter, wraps 0xFFFF -> 0
module light_sensor_emulator #(
    parameter int LEAD_ZEROS = 4,
    parameter int DATA_W     = 8,
    parameter int FRAME_BITS = 16
) (
    input  logic              clk_10Mhz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              sdata,
    output logic              sdata_oe,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frame_count
);

    localparam int IDX_W       = $clog2(FRAME_BITS + 1);
    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_W;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    // Whole frame image: leading zeros fall out of the zero-extension, the
    // shift positions the data ahead of the trailing zeros.
    function automatic logic [FRAME_BITS-1:0] frame_image(input logic [DATA_W-1:0] value);
        return FRAME_BITS'(value) << TRAIL_ZEROS;
    endfunction

    // Input synchronisers: two flops, third flop for edge detection
    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic sclk_p0, sclk_p1, sclk_p2;

    always_ff @(posedge clk_10Mhz) begin
        if (reset) begin
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
        end else begin
            cs_n_p0 <= cs_n;
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
        end
    end

    logic cs_fall, cs_rise, sclk_fall;
    assign cs_fall   = cs_n_p2 & ~cs_n_p1;
    assign cs_rise   = ~cs_n_p2 & cs_n_p1;
    assign sclk_fall = sclk_p2 & ~sclk_p1;

    // The synchroniser restarts from cs_n=1, so a reset while the pin is low
    // would otherwise look like a fresh falling edge. Frames are only accepted
    // once the synchronised chip select has been seen high after reset.
    logic [1:0] settle_cnt;
    logic       armed;

    always_ff @(posedge clk_10Mhz) begin
        if (reset) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != 2'd3)
                settle_cnt <= settle_cnt + 2'd1;
            if (settle_cnt == 2'd3 && cs_n_p2)
                armed <= 1'b1;
        end
    end

    // Holding register: accepts a new value at any time; the frame in flight
    // works from its own copy in frame_sr.
    logic [DATA_W-1:0] hold_reg;

    always_ff @(posedge clk_10Mhz) begin
        if (reset)
            hold_reg <= '0;
        else if (sample_valid)
            hold_reg <= sample_in;
    end

    // Frame state machine
    state_t                state_q, state_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic [FRAME_BITS-1:0] frame_sr, frame_sr_nxt;
    logic                  done_q, done_nxt;
    logic                  abort_q, abort_nxt;
    logic [15:0]           count_q, count_nxt;

    always_ff @(posedge clk_10Mhz) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            done_q  <= done_nxt;
            abort_q <= abort_nxt;
            count_q <= count_nxt;
        end
    end

    // Data shift register needs no reset: sdata is gated by state.
    always_ff @(posedge clk_10Mhz) begin
        frame_sr <= frame_sr_nxt;
    end

    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        frame_sr_nxt = frame_sr;
        done_nxt     = 1'b0;
        abort_nxt    = 1'b0;
        count_nxt    = count_q;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed) begin
                    frame_sr_nxt = frame_image(hold_reg);
                    idx_nxt      = '0;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // CS rise wins over a simultaneous sclk strobe
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sclk_fall) begin
                    frame_sr_nxt = frame_sr << 1;
                    if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
                        idx_nxt   = IDX_W'(FRAME_BITS);
                        state_nxt = HOLD;
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    count_nxt = count_q + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sdata       = (state_q == SHIFT) ? frame_sr[FRAME_BITS-1] : 1'b0;
    assign sdata_oe    = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_light_sensor_emulator.sv
// tb_light_sensor_emulator
//   Directed and randomized SPI frames against a behavioural model of the
//   light-sensor ADC: expected serial streams are computed from the frame
//   layout (4 zeros, 8 data bits MSB first, zeros after), pulse and counter
//   expectations from whether the master clocked a full frame.
module tb_light_sensor_emulator;

    logic       clk_10Mhz = 1'b0;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       cs_n;
    logic       sclk;
    logic       sdata;
    logic       sdata_oe;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;
    logic [15:0] frame_count;

    light_sensor_emulator #(
        .LEAD_ZEROS(4),
        .DATA_W    (8),
        .FRAME_BITS(16)
    ) dut (
        .clk_10Mhz   (clk_10Mhz),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .sdata       (sdata),
        .sdata_oe    (sdata_oe),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_count (frame_count)
    );

    always #50 clk_10Mhz = ~clk_10Mhz;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen  = 0;
    int abort_seen = 0;

    always @(negedge clk_10Mhz) begin
        if (frame_done === 1'b1)  done_seen++;
        if (frame_abort === 1'b1) abort_seen++;
    end

    // Reference model state
    logic [7:0]  m_hold;
    logic [15:0] m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream a master sees over nbits rising edges for a given light value
    function automatic logic [31:0] expected_stream(input logic [7:0] data, input int nbits);
        logic [31:0] s;
        logic        b;
        s = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (i >= 4 && i < 12) ? data[11 - i] : 1'b0;
            s = {s[30:0], b};
        end
        return s;
    endfunction

    task automatic load_sample(input logic [7:0] v);
        @(negedge clk_10Mhz);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk_10Mhz);
        sample_valid = 1'b0;
        m_hold = v;
    endtask

    // One master frame at 1 MHz sclk; optional sample load after fall number load_at
    task automatic frame_and_check(input string tag, input int nfalls,
                                   input int load_at, input logic [7:0] load_val);
        logic [31:0] cap;
        logic [7:0]  exp_data;
        int          d0, a0;
        bit          full;
        cap      = '0;
        exp_data = m_hold;
        d0       = done_seen;
        a0       = abort_seen;
        cs_n = 1'b0;
        #500;
        chk({tag, "_oe_start"}, {31'd0, sdata_oe}, 32'd1);
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < nfalls; i++) begin
            cap  = {cap[30:0], sdata};
            sclk = 1'b1;
            #500;
            sclk = 1'b0;
            if (i == load_at) load_sample(load_val);
            #500;
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        #1000;
        full = (nfalls >= 16);
        if (full) m_count = m_count + 16'd1;
        chk({tag, "_stream"}, cap, expected_stream(exp_data, nfalls));
        chk({tag, "_done"}, done_seen - d0, full ? 32'd1 : 32'd0);
        chk({tag, "_abort"}, abort_seen - a0, full ? 32'd0 : 32'd1);
        chk({tag, "_count"}, {16'd0, frame_count}, {16'd0, m_count});
        chk({tag, "_oe_end"}, {31'd0, sdata_oe}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0, a0, nf, la;
        logic [7:0] v;
        reset        = 1'b1;
        cs_n         = 1'b1;
        sclk         = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        m_hold       = 8'h00;
        m_count      = 16'h0000;
        repeat (5) @(negedge clk_10Mhz);

        chk("rst_sdata", {31'd0, sdata}, 32'd0);
        chk("rst_oe", {31'd0, sdata_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_abort", {31'd0, frame_abort}, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk_10Mhz);

        // Basic frame
        load_sample(8'hA5);
        frame_and_check("t1", 16, -1, 8'h00);

        // Mid-frame load must not disturb the frame in flight
        frame_and_check("t2a", 16, 5, 8'h3C);
        frame_and_check("t2b", 16, -1, 8'h00);

        // Early CS rise, then a clean frame
        load_sample(8'h5A);
        frame_and_check("t3a", 7, -1, 8'h00);
        frame_and_check("t3b", 16, -1, 8'h00);

        // Overclocked frame: trailing bits stay zero, one frame_done
        load_sample(8'hFF);
        frame_and_check("t4", 20, -1, 8'h00);

        // Reset mid-frame with CS held low
        load_sample(8'hC3);
        d0 = done_seen;
        a0 = abort_seen;
        cs_n = 1'b0;
        #500;
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            #500;
            sclk = 1'b0;
            #500;
        end
        @(negedge clk_10Mhz);
        reset = 1'b1;
        @(negedge clk_10Mhz);
        reset = 1'b0;
        m_count = 16'h0000;
        m_hold  = 8'h00;
        chk("t5_oe", {31'd0, sdata_oe}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_sdata", {31'd0, sdata}, 32'd0);
        chk("t5_count", {16'd0, frame_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            #500;
            sclk = 1'b0;
            #500;
        end
        chk("t5_wait_busy", {31'd0, busy}, 32'd0);
        cs_n = 1'b1;
        #1000;
        chk("t5_no_done", done_seen - d0, 32'd0);
        chk("t5_no_abort", abort_seen - a0, 32'd0);
        frame_and_check("t5_zero", 16, -1, 8'h00);
        load_sample(8'h96);
        frame_and_check("t5_next", 16, -1, 8'h00);

        // Randomized frames: random values, lengths and load points
        for (int k = 0; k < 8; k++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 1) == 1) load_sample(v);
            nf = $urandom_range(1, 22);
            la = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nf - 1) : -1;
            frame_and_check($sformatf("rnd%0d", k), nf, la, 8'($urandom));
        end

        // Counter wrap
        force dut.count_q = 16'hFFFF;
        repeat (2) @(negedge clk_10Mhz);
        release dut.count_q;
        m_count = 16'hFFFF;
        @(negedge clk_10Mhz);
        chk("t6_preload", {16'd0, frame_count}, 32'h0000FFFF);
        frame_and_check("t6_wrap", 16, -1, 8'h00);
        chk("t6_zero", {16'd0, frame_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
